// File: rtl/fifo_pkg.sv
// fifo_pkg: shared width helpers and flag-level legality check
// for the fifo_ctrl block and its pointer sub-module.
package fifo_pkg;

    // Pointer width; at least one bit so a 1-entry range never collapses.
    function automatic int addr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Occupancy width; must hold the value DEPTH itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Legal flag thresholds: 1 <= AF <= DEPTH, 0 <= AE <= DEPTH-1.
    function automatic bit levels_ok(
        input int depth,
        input int af,
        input int ae
    );
        return (depth >= 2) &&
               (af >= 1) && (af <= depth) &&
               (ae >= 0) && (ae <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrapping RAM address counter, 0..DEPTH-1.
// Wraps explicitly so non-power-of-2 depths work.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst,
    input  logic                      i_Inc,
    output logic [addr_w(DEPTH)-1:0]  o_Ptr
);

    localparam int            AW   = addr_w(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;

    // Next pointer: advance on accept, wrap from LAST to 0.
    always_comb begin
        ptr_d = ptr_q;
        if (i_Inc) begin
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + AW'(1);
        end
    end

    // Pointer register with synchronous reset.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

    assign o_Ptr = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: single-clock FIFO controller in front of a 2-port RAM.
// Optional macro FIFO_ERR_STICKY_EN adds sticky overflow/underflow.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 256,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst,
    input  logic                      i_Wr_DV,
    input  logic [WIDTH-1:0]          i_Wr_Data,
    input  logic                      i_Rd_En,
    output logic                      o_Rd_DV,
    output logic [WIDTH-1:0]          o_Rd_Data,
    output logic                      o_Full,
    output logic                      o_Empty,
    output logic                      o_AF_Flag,
    output logic                      o_AE_Flag,
    output logic [cnt_w(DEPTH)-1:0]   o_Count,
    output logic [addr_w(DEPTH)-1:0]  o_Ram_Wr_Addr,
    output logic                      o_Ram_Wr_DV,
    output logic [WIDTH-1:0]          o_Ram_Wr_Data,
    output logic [addr_w(DEPTH)-1:0]  o_Ram_Rd_Addr,
    output logic                      o_Ram_Rd_En,
`ifdef FIFO_ERR_STICKY_EN
    output logic                      o_Overflow,
    output logic                      o_Underflow,
`endif
    input  logic                      i_Ram_Rd_DV,
    input  logic [WIDTH-1:0]          i_Ram_Rd_Data
);

    localparam int CW = cnt_w(DEPTH);

    if (!levels_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_levels
        $error("fifo_ctrl: illegal DEPTH/AF_LEVEL/AE_LEVEL");
    end

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          full;
    logic          empty;
    logic          wr_ok;
    logic          rd_ok;

    // Flags come only from the count register, never from requests.
    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);

    assign wr_ok = i_Wr_DV & ~full;
    assign rd_ok = i_Rd_En & ~empty;

    fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .i_Inc (wr_ok),
        .o_Ptr (o_Ram_Wr_Addr)
    );

    fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .i_Inc (rd_ok),
        .o_Ptr (o_Ram_Rd_Addr)
    );

    // Occupancy next-state: net change of accepted write and read.
    always_comb begin
        cnt_d = cnt_q;
        case ({wr_ok, rd_ok})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Occupancy register; reset wins over any same-cycle request.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign o_Count   = cnt_q;
    assign o_Full    = full;
    assign o_Empty   = empty;
    assign o_AF_Flag = (cnt_q >= CW'(AF_LEVEL));
    assign o_AE_Flag = (cnt_q <= CW'(AE_LEVEL));

    // Strobes to the RAM and back to the user are held off in reset.
    assign o_Ram_Wr_DV   = wr_ok & ~i_Rst;
    assign o_Ram_Rd_En   = rd_ok & ~i_Rst;
    assign o_Ram_Wr_Data = i_Wr_Data;
    assign o_Rd_DV       = i_Ram_Rd_DV & ~i_Rst;
    assign o_Rd_Data     = i_Ram_Rd_Data;

`ifdef FIFO_ERR_STICKY_EN
    logic ovf_q;
    logic unf_q;

    // Sticky error bits for requests dropped at full or empty.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | (i_Wr_DV & full);
            unf_q <= unf_q | (i_Rd_En & empty);
        end
    end

    assign o_Overflow  = ovf_q;
    assign o_Underflow = unf_q;
`endif

endmodule
